cam_match_encoder: RTL
======================

CAM_MATCH_ENCODER -- requirements
Module: cam_match_encoder

Interface
REQ-001 Parameters SHALL be:
- CAM_WIDTH, default 8, search word width.
- CAM_DEPTH, default 8, number of CAM rows.
- MATCH_LAT, default 1, cycles from search_word driven to decoded_match_address valid.
- ADDR_W, default clog2(CAM_DEPTH), encoded row address width.

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_req  in  1  write request.
- wr_addr  in  ADDR_W  binary row to write.
- wr_ready  out  1  write accepted this cycle.
- we_decoded_row_address  out  CAM_DEPTH  one-hot row write enable to CAM.
- srch_valid  in  1  search request.
- srch_ready  out  1  search accepted.
- srch_key  in  CAM_WIDTH  key / write data.
- srch_mask  in  CAM_WIDTH  don't-care mask.
- search_word  out  CAM_WIDTH  to CAM.
- dont_care_mask  out  CAM_WIDTH  to CAM.
- decoded_match_address  in  CAM_DEPTH  per-row match from CAM.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_hit  out  1  at least one row matched.
- res_addr  out  ADDR_W  encoded matching row.
- res_multi  out  1  more than one row matched.
- res_last  out  1  final result of this search.

Function
REQ-003 FSM states SHALL be IDLE, LAUNCH, CAPTURE, EMIT.
REQ-004 wr_ready and srch_ready SHALL be high only in IDLE.
REQ-005 In IDLE, if wr_req and srch_valid are both high, the write SHALL win and srch_ready SHALL drop that cycle.
REQ-006 An accepted write SHALL register search_word=srch_key and dont_care_mask=srch_mask, and pulse we_decoded_row_address bit wr_addr for exactly one cycle on the next cycle.
REQ-007 A wr_addr >= CAM_DEPTH SHALL be accepted and produce an all-zero enable.
REQ-008 An accepted search SHALL register srch_key and srch_mask onto search_word and dont_care_mask, then enter LAUNCH.
REQ-009 search_word and dont_care_mask SHALL hold stable until the FSM returns to IDLE.
REQ-010 LAUNCH SHALL count MATCH_LAT cycles, then enter CAPTURE.
REQ-011 CAPTURE SHALL latch decoded_match_address into a pending vector and compute res_multi as popcount > 1, then enter EMIT.
REQ-012 In EMIT, res_valid SHALL be high and res_addr SHALL be the lowest set index of the pending vector.
REQ-013 In EMIT, res_hit SHALL be 1 if the pending vector is non-zero, and res_last SHALL be 1 when at most one bit is set.
REQ-014 A miss SHALL produce exactly one result: res_hit=0, res_addr=0, res_multi=0, res_last=1.
REQ-015 On res_valid & res_ready, the reported bit SHALL be cleared from the pending vector; if res_last=1, the FSM SHALL return to IDLE.
REQ-016 res_* outputs SHALL hold stable while res_valid & !res_ready (back-pressure).
REQ-017 The minimum latency from search accept to res_valid SHALL be MATCH_LAT+2 cycles.
REQ-018 The minimum turnaround SHALL allow a new search to be accepted in the cycle after the last result is consumed.

Reset
REQ-019 While rst=0, the FSM SHALL be IDLE and all outputs SHALL be 0, except wr_ready and srch_ready, which SHALL be 1 once rst=1.
REQ-020 Reset asserted mid-search SHALL abandon the search with no result emitted and SHALL clear the pending vector.

Configuration
REQ-021 With CAM_MULTI_HIT_EN defined, EMIT SHALL iterate over every matching row in ascending index order, per REQ-012 to REQ-015.
REQ-022 Without CAM_MULTI_HIT_EN, exactly one result per search SHALL be emitted: the lowest index, with res_last=1 and res_multi still reporting popcount > 1.

Structure
REQ-023 Shared package cam_pkg SHALL hold the FSM state enum, the ADDR_W/clog2 helper, and the default CAM_WIDTH/CAM_DEPTH constants.
REQ-024 Sub-module cam_priority_enc (combinational: vector in; lowest index, any-set and more-than-one-set out) SHALL be instantiated once.

Verification
REQ-025 Write key 0x5A to row 3: the enable SHALL equal 0x08 for one cycle, and search_word SHALL equal 0x5A.
REQ-026 Search 0x5A with mask 0x00 and match vector 0x08: one result SHALL be produced with hit=1, addr=3, multi=0, last=1, at MATCH_LAT+2 cycles after accept.
REQ-027 Match vector 0x94 with MULTI_HIT_EN defined: results SHALL be addr 2, 4, 7 with last only on 7 and multi=1 throughout; without the macro, a single result addr=2, multi=1, last=1.
REQ-028 Match vector 0x00: one result SHALL be produced with hit=0, addr=0, last=1.
REQ-029 Hold res_ready=0 for 5 cycles: res_* SHALL stay stable; simultaneous wr_req and srch_valid in IDLE: the write SHALL be taken and the search accepted next cycle.
REQ-030 Assert rst=0 during LAUNCH: all outputs SHALL be 0, no res_valid SHALL be produced, and the block SHALL be IDLE after release.

Source files
------------

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types, defaults and helpers for the CAM match encoder
//
// Purpose : FSM state enum, default CAM geometry and the address-width helper
//           used by cam_match_encoder and cam_priority_enc.
// Ports   : none (package).
package cam_pkg;

    localparam int CAM_WIDTH_DEF = 8;
    localparam int CAM_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        CAPTURE = 2'd2,
        EMIT    = 2'd3
    } cam_state_t;

    // Never return 0 so a one-row CAM still gets a 1-bit address port.
    function automatic int cam_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cam_priority_enc.sv
// rtl/cam_priority_enc.sv - combinational lowest-index priority encoder
//
// Purpose : reduce a match vector to its lowest set index plus any-set and
//           more-than-one-set flags.
// Ports   : i_vec   [W-1:0]  vector to encode
//           o_idx   [AW-1:0] lowest set index (0 when vector is empty)
//           o_any            at least one bit set
//           o_multi          more than one bit set
module cam_priority_enc #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic [W-1:0]  i_vec,
    output logic [AW-1:0] o_idx,
    output logic          o_any,
    output logic          o_multi
);

    // Scan high to low so the last assignment is the lowest set bit.
    always_comb begin
        o_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = AW'(i);
            end
        end
    end

    assign o_any   = |i_vec;
    // v & (v-1) drops the lowest set bit; anything left means popcount > 1.
    assign o_multi = |(i_vec & (i_vec - W'(1)));

endmodule

// File: rtl/cam_match_encoder.sv
// rtl/cam_match_encoder.sv - CAM write/search sequencer and match-address encoder
//
// Purpose : accepts row writes and key searches, drives the CAM search word,
//           mask and one-hot write enable, waits MATCH_LAT cycles for the CAM
//           match vector, then emits encoded results with valid/ready.
// Config  : CAM_MULTI_HIT_EN - when defined, every matching row is reported in
//           ascending order; otherwise only the lowest matching row is reported.
// Ports   : clk, rst (async active-low)
//           wr_req/wr_addr/wr_ready         write request channel
//           we_decoded_row_address          one-hot row write enable to CAM
//           srch_valid/srch_ready           search request channel
//           srch_key/srch_mask              key (also write data) and mask
//           search_word/dont_care_mask      registered drive to CAM
//           decoded_match_address           per-row match vector from CAM
//           res_valid/res_ready             result channel handshake
//           res_hit/res_addr/res_multi/res_last  result fields
module cam_match_encoder
    import cam_pkg::*;
#(
    parameter int CAM_WIDTH = CAM_WIDTH_DEF,
    parameter int CAM_DEPTH = CAM_DEPTH_DEF,
    parameter int MATCH_LAT = 1,
    parameter int ADDR_W    = cam_clog2(CAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_req,
    input  logic [ADDR_W-1:0]    wr_addr,
    output logic                 wr_ready,
    output logic [CAM_DEPTH-1:0] we_decoded_row_address,
    input  logic                 srch_valid,
    output logic                 srch_ready,
    input  logic [CAM_WIDTH-1:0] srch_key,
    input  logic [CAM_WIDTH-1:0] srch_mask,
    output logic [CAM_WIDTH-1:0] search_word,
    output logic [CAM_WIDTH-1:0] dont_care_mask,
    input  logic [CAM_DEPTH-1:0] decoded_match_address,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_hit,
    output logic [ADDR_W-1:0]    res_addr,
    output logic                 res_multi,
    output logic                 res_last
);

    localparam int CNT_W  = cam_clog2(MATCH_LAT + 1);
    localparam int LAT_M1 = (MATCH_LAT > 0) ? MATCH_LAT - 1 : 0;

    cam_state_t           r_state;
    cam_state_t           w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CAM_DEPTH-1:0] r_pend;
    logic                 r_multi;
    logic [CAM_WIDTH-1:0] r_word;
    logic [CAM_WIDTH-1:0] r_mask;
    logic [CAM_DEPTH-1:0] r_we;

    logic [CAM_DEPTH-1:0] w_we_onehot;
    logic [CAM_DEPTH-1:0] w_enc_vec;
    logic [ADDR_W-1:0]    w_enc_idx;
    logic                 w_enc_any;
    logic                 w_enc_multi;
    logic                 w_wr_take;
    logic                 w_srch_take;
    logic                 w_res_fire;

    // The single encoder serves two phases: popcount of the raw CAM vector
    // in CAPTURE, and lowest-index of the pending vector in EMIT.
    assign w_enc_vec = (r_state == CAPTURE) ? decoded_match_address : r_pend;

    cam_priority_enc #(
        .W  (CAM_DEPTH),
        .AW (ADDR_W)
    ) u_prio (
        .i_vec   (w_enc_vec),
        .o_idx   (w_enc_idx),
        .o_any   (w_enc_any),
        .o_multi (w_enc_multi)
    );

    // Rows beyond CAM_DEPTH never compare equal, giving an all-zero enable.
    always_comb begin
        w_we_onehot = '0;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            w_we_onehot[i] = (32'(wr_addr) == i);
        end
    end

    // Readies are gated by rst so they read 0 while reset is held.
    assign wr_ready    = rst && (r_state == IDLE);
    assign srch_ready  = wr_ready && !wr_req;
    assign w_wr_take   = wr_ready && wr_req;
    assign w_srch_take = srch_ready && srch_valid;

    assign res_valid  = (r_state == EMIT);
    assign res_hit    = res_valid && w_enc_any;
    assign res_addr   = res_valid ? w_enc_idx : '0;
    assign res_multi  = res_valid && r_multi;
`ifdef CAM_MULTI_HIT_EN
    assign res_last   = res_valid && !w_enc_multi;
`else
    assign res_last   = res_valid;
`endif
    assign w_res_fire = res_valid && res_ready;

    assign search_word            = r_word;
    assign dont_care_mask         = r_mask;
    assign we_decoded_row_address = r_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_srch_take) begin
                    w_state_nxt = (MATCH_LAT == 0) ? CAPTURE : LAUNCH;
                end
            end
            LAUNCH: begin
                if (r_cnt == CNT_W'(LAT_M1)) begin
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                w_state_nxt = EMIT;
            end
            EMIT: begin
                if (w_res_fire && res_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_pend  <= '0;
            r_multi <= 1'b0;
            r_word  <= '0;
            r_mask  <= '0;
            r_we    <= '0;
        end else begin
            r_we <= '0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_wr_take) begin
                        r_word <= srch_key;
                        r_mask <= srch_mask;
                        r_we   <= w_we_onehot;
                    end else if (w_srch_take) begin
                        r_word <= srch_key;
                        r_mask <= srch_mask;
                    end
                end
                LAUNCH: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                CAPTURE: begin
                    r_pend  <= decoded_match_address;
                    r_multi <= w_enc_multi;
                end
                EMIT: begin
                    if (w_res_fire) begin
                        if (res_last) begin
                            r_pend  <= '0;
                            r_multi <= 1'b0;
                        end else begin
                            // Retire the row just reported (lowest set bit).
                            r_pend <= r_pend & (r_pend - CAM_DEPTH'(1));
                        end
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule
